// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - APB master front-end arbitrating NUM_CH valid/ready requesters
module core_mem_arbiter #(
  parameter int NUM_CH         = 2,
  parameter int ARB_RR         = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     req_valid,
  output logic [NUM_CH-1:0]     req_ready,
  input  logic [NUM_CH*32-1:0]  req_addr,
  input  logic [NUM_CH-1:0]     req_write,
  input  logic [NUM_CH*32-1:0]  req_wdata,
  input  logic [NUM_CH*4-1:0]   req_wstrb,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           paddr,
  output logic [31:0]           pwdata,
  output logic [3:0]            pwstrb,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [31:0]           prdata
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETUP = 2'd1, ST_ACCESS = 2'd2} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_grant;   // current grant, doubles as the round-robin last_grant pointer
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] w_cand;
  logic [2:0]        w_pick;
  logic              w_pick_vld;
  logic              w_tmo;
  logic              w_done;
  logic              w_load;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_strb;
  logic              w_wr;
  int                w_dist;
  int                w_best;

  assign w_tmo  = (TIMEOUT_CYCLES != 0) && (r_cnt == TMO_LAST);
  assign w_done = (r_state == ST_ACCESS) && (pready || w_tmo);

  // Arbitration: mask the completing channel, then pick the valid channel nearest the priority origin
  always_comb begin
    w_cand     = req_valid;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_dist     = 0;
    w_best     = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((r_state == ST_ACCESS) && (r_grant == 3'(i))) w_cand[i] = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      w_dist = (ARB_RR != 0) ? ((i + NUM_CH - 1 - int'(r_grant)) % NUM_CH) : i;
      if (w_cand[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_pick     = 3'(i);
        w_pick_vld = 1'b1;
      end
    end
  end

  // Payload mux of the channel about to be granted
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_strb  = '0;
    w_wr    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_pick == 3'(i)) begin
        w_addr  = req_addr[32*i +: 32];
        w_wdata = req_wdata[32*i +: 32];
        w_strb  = req_wstrb[4*i +: 4];
        w_wr    = req_write[i];
      end
    end
  end

  // Next-state logic; a grant loads from IDLE or directly from a completing ACCESS
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_next = ST_SETUP;
          w_load = 1'b1;
        end
      end
      ST_SETUP: w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (w_done) begin
          if (w_pick_vld) begin
            w_next = ST_SETUP;
            w_load = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Grant and APB payload capture; reads never carry byte strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= 3'(NUM_CH - 1);
      paddr   <= '0;
      pwdata  <= '0;
      pwstrb  <= '0;
      pwrite  <= 1'b0;
    end else if (w_load) begin
      r_grant <= w_pick;
      paddr   <= w_addr;
      pwdata  <= w_wdata;
      pwstrb  <= w_wr ? w_strb : 4'b0;
      pwrite  <= w_wr;
    end
  end

  // ACCESS wait counter, zeroed during SETUP so it starts at 0 in the first ACCESS cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_cnt <= '0;
    else if (r_state == ST_SETUP)           r_cnt <= '0;
    else if (r_state == ST_ACCESS && !pready) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Completion outputs; a timeout reports an error with zero data, pready takes precedence
  always_comb begin
    psel      = (r_state != ST_IDLE);
    penable   = (r_state == ST_ACCESS);
    rsp_rdata = (w_done && pready) ? prdata : 32'h0;
    rsp_err   = w_done && (!pready || pslverr);
    req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_ready[i] = w_done && (r_grant == 3'(i));
    end
  end

endmodule
